// File: rtl/mm_control_initiator.sv
// Host-side initiator for the videocard control port: writes the start command,
// then polls the finish register until it reads 1 or the poll budget runs out.
module mm_control_initiator #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned POLL_GAP  = 4,
    parameter int unsigned MAX_POLLS = 1024,
    parameter int unsigned COOLDOWN  = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             kick,
    output logic             address,
    output logic             write,
    output logic             read,
    output logic [WIDTH-1:0] data_write,
    input  logic [WIDTH-1:0] data_read,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [15:0]      poll_count
);

    localparam int unsigned CNT_MAX = (POLL_GAP > COOLDOWN) ? POLL_GAP : COOLDOWN;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        GAP   = 3'd2,
        READ  = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5,
        TMO   = 3'd6,
        COOL  = 3'd7
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;

    logic               address_d;
    logic               write_d;
    logic               read_d;
    logic [WIDTH-1:0]   data_write_d;
    logic               busy_d;
    logic               done_d;
    logic               timeout_d;
    logic [15:0]        poll_count_d;

    // State and shared gap/cooldown counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Next-state and counter reload/decrement
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE: begin
                if (kick) state_d = WRITE;
            end
            WRITE: begin
                state_d = GAP;
                cnt_d   = CNT_W'(POLL_GAP - 1);
            end
            GAP: begin
                if (cnt == '0) state_d = READ;
                else           cnt_d   = cnt - CNT_W'(1);
            end
            READ: begin
                state_d = CHECK;
            end
            CHECK: begin
                // poll_count already includes the read that produced this data
                if (data_read == WIDTH'(1)) begin
                    state_d = DONE;
                end else if (poll_count == 16'(MAX_POLLS)) begin
                    state_d = TMO;
                end else begin
                    state_d = GAP;
                    cnt_d   = CNT_W'(POLL_GAP - 1);
                end
            end
            DONE, TMO: begin
                state_d = COOL;
                cnt_d   = CNT_W'(COOLDOWN - 1);
            end
            COOL: begin
                if (cnt == '0) state_d = IDLE;
                else           cnt_d   = cnt - CNT_W'(1);
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output values for the upcoming state, registered below
    always_comb begin
        address_d    = address;
        write_d      = 1'b0;
        read_d       = 1'b0;
        data_write_d = '0;
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == DONE);
        timeout_d    = (state_d == TMO);
        poll_count_d = poll_count;
        case (state_d)
            WRITE: begin
                address_d    = 1'b0;
                write_d      = 1'b1;
                data_write_d = WIDTH'(1);
                poll_count_d = '0;
            end
            READ: begin
                address_d = 1'b1;
                read_d    = 1'b1;
                if (poll_count != 16'hFFFF) poll_count_d = poll_count + 16'd1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            address    <= 1'b0;
            write      <= 1'b0;
            read       <= 1'b0;
            data_write <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            poll_count <= '0;
        end else begin
            address    <= address_d;
            write      <= write_d;
            read       <= read_d;
            data_write <= data_write_d;
            busy       <= busy_d;
            done       <= done_d;
            timeout    <= timeout_d;
            poll_count <= poll_count_d;
        end
    end

endmodule

// File: tb/tb_mm_control_initiator.sv
// Directed bench for mm_control_initiator: a responder that returns finish on a chosen
// read, a negedge monitor that logs strobe timing, and one task per scenario.
module tb_mm_control_initiator;

    logic        clk = 1'b0;
    logic        reset;
    logic        kick;
    logic        address;
    logic        write;
    logic        read;
    logic [7:0]  data_write;
    logic [7:0]  data_read;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [15:0] poll_count;

    int tests = 0;
    int fails = 0;

    int cyc = 0;
    int n_wr = 0, n_rd = 0, n_done = 0, n_tmo = 0;
    int bad_wr = 0, bad_rd = 0, overlap = 0, n_bfall = 0, n_brise = 0;
    int wr_cyc = 0, first_rd_cyc = 0, rd_last = 0, rd_prev = 0;
    int done_cyc = 0, tmo_cyc = 0, bfall_cyc = 0, rd_since_wr = 0;
    logic busy_prev = 1'b0;

    int         finish_at = 1;
    logic [7:0] bad_val = 8'h00;
    int         k_cyc = 0;

    mm_control_initiator #(
        .WIDTH(8), .POLL_GAP(4), .MAX_POLLS(5), .COOLDOWN(24)
    ) dut (
        .clk(clk), .reset(reset), .kick(kick), .address(address), .write(write),
        .read(read), .data_write(data_write), .data_read(data_read), .busy(busy),
        .done(done), .timeout(timeout), .poll_count(poll_count)
    );

    always #5 clk = ~clk;

    // Target model: finish register reads 1 only after the chosen read strobe
    assign data_read = (n_rd == finish_at) ? 8'h01 : bad_val;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (write) begin
            n_wr        <= n_wr + 1;
            wr_cyc      <= cyc + 1;
            rd_since_wr <= 0;
            if (address !== 1'b0 || data_write !== 8'h01) bad_wr <= bad_wr + 1;
        end
        if (read) begin
            n_rd        <= n_rd + 1;
            rd_prev     <= rd_last;
            rd_last     <= cyc + 1;
            rd_since_wr <= rd_since_wr + 1;
            if (rd_since_wr == 0) first_rd_cyc <= cyc + 1;
            if (address !== 1'b1 || data_write !== 8'h00) bad_rd <= bad_rd + 1;
        end
        if (write && read) overlap <= overlap + 1;
        if (done && timeout) overlap <= overlap + 1;
        if (done) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc + 1;
        end
        if (timeout) begin
            n_tmo   <= n_tmo + 1;
            tmo_cyc <= cyc + 1;
        end
        if (busy_prev && !busy) begin
            n_bfall   <= n_bfall + 1;
            bfall_cyc <= cyc + 1;
        end
        if (!busy_prev && busy) n_brise <= n_brise + 1;
        busy_prev <= busy;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic kick_once();
        step();
        kick  = 1'b1;
        k_cyc = cyc;
        step();
        kick = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        reset = 1'b1;
        kick  = 1'b1;
        finish_at = 1;
        repeat (3) step();
        tests++;
        if ({address, write, read, data_write, busy, done, timeout, poll_count} !== 31'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {address, write, read, data_write, busy, done, timeout, poll_count});
        end
        reset = 1'b0;
        #1;
        tests++;
        if (write !== 1'b0 || read !== 1'b0) begin
            fails++;
            $display("FAIL reset_no_strobe: got write=%b read=%b expected 0 0", write, read);
        end
        step();
        tests++;
        if (write !== 1'b1 || address !== 1'b0 || data_write !== 8'h01) begin
            fails++;
            $display("FAIL reset_first_write: got write=%b addr=%b data=%h expected 1 0 01",
                     write, address, data_write);
        end
        kick = 1'b0;
        wait_idle(ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL reset_txn_end: got busy stuck expected idle");
        end
    endtask

    task automatic test_finish_third();
        bit ok;
        int b_wr, b_rd, b_done, b_tmo, b_bw, b_br;
        b_wr = n_wr; b_rd = n_rd; b_done = n_done; b_tmo = n_tmo; b_bw = bad_wr; b_br = bad_rd;
        bad_val   = 8'h00;
        finish_at = n_rd + 3;
        kick_once();
        wait_idle(ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL f3_idle: got busy stuck expected idle"); end
        tests++;
        if (n_wr - b_wr != 1) begin fails++; $display("FAIL f3_writes: got %0d expected 1", n_wr - b_wr); end
        tests++;
        if (wr_cyc != k_cyc + 1) begin fails++; $display("FAIL f3_kick_lat: got %0d expected 1", wr_cyc - k_cyc); end
        tests++;
        if (bad_wr != b_bw || bad_rd != b_br) begin
            fails++;
            $display("FAIL f3_addr_data: got bad_wr=%0d bad_rd=%0d expected 0 0", bad_wr - b_bw, bad_rd - b_br);
        end
        tests++;
        if (n_rd - b_rd != 3) begin fails++; $display("FAIL f3_reads: got %0d expected 3", n_rd - b_rd); end
        tests++;
        if (first_rd_cyc - wr_cyc != 5) begin
            fails++; $display("FAIL f3_wr_to_rd: got %0d expected 5", first_rd_cyc - wr_cyc);
        end
        tests++;
        if (rd_last - rd_prev != 6) begin fails++; $display("FAIL f3_rd_spacing: got %0d expected 6", rd_last - rd_prev); end
        tests++;
        if (n_done - b_done != 1 || n_tmo != b_tmo) begin
            fails++; $display("FAIL f3_done: got done=%0d tmo=%0d expected 1 0", n_done - b_done, n_tmo - b_tmo);
        end
        tests++;
        if (done_cyc - rd_last != 2) begin fails++; $display("FAIL f3_done_lat: got %0d expected 2", done_cyc - rd_last); end
        tests++;
        if (poll_count !== 16'd3) begin fails++; $display("FAIL f3_poll_count: got %0d expected 3", poll_count); end
        tests++;
        if (bfall_cyc - done_cyc != 25) begin
            fails++; $display("FAIL f3_cooldown: got %0d expected 25", bfall_cyc - done_cyc);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int b_rd, b_done, b_tmo;
        b_rd = n_rd; b_done = n_done; b_tmo = n_tmo;
        bad_val   = 8'h00;
        finish_at = -1;
        kick_once();
        wait_idle(ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL tmo_idle: got busy stuck expected idle"); end
        tests++;
        if (n_rd - b_rd != 5) begin fails++; $display("FAIL tmo_reads: got %0d expected 5", n_rd - b_rd); end
        tests++;
        if (n_tmo - b_tmo != 1 || n_done != b_done) begin
            fails++; $display("FAIL tmo_pulse: got tmo=%0d done=%0d expected 1 0", n_tmo - b_tmo, n_done - b_done);
        end
        tests++;
        if (tmo_cyc - rd_last != 2) begin fails++; $display("FAIL tmo_lat: got %0d expected 2", tmo_cyc - rd_last); end
        tests++;
        if (poll_count !== 16'd5) begin fails++; $display("FAIL tmo_poll_count: got %0d expected 5", poll_count); end
    endtask

    task automatic test_kick_ignored();
        bit ok;
        int b_wr, b_rise, b_fall, b_done;
        b_wr = n_wr; b_rise = n_brise; b_fall = n_bfall; b_done = n_done;
        bad_val   = 8'h00;
        finish_at = n_rd + 1;
        kick_once();
        step();
        kick = 1'b1;
        step();
        kick = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (done) begin ok = 1'b1; break; end
        end
        tests++;
        if (!ok) begin fails++; $display("FAIL ign_done_seen: got no done expected done"); end
        repeat (3) step();
        kick = 1'b1;
        step();
        kick = 1'b0;
        wait_idle(ok);
        repeat (10) step();
        tests++;
        if (n_wr - b_wr != 1) begin fails++; $display("FAIL ign_writes: got %0d expected 1", n_wr - b_wr); end
        tests++;
        if (n_brise - b_rise != 1 || n_bfall - b_fall != 1) begin
            fails++;
            $display("FAIL ign_busy_cont: got rises=%0d falls=%0d expected 1 1", n_brise - b_rise, n_bfall - b_fall);
        end
        tests++;
        if (n_done - b_done != 1) begin fails++; $display("FAIL ign_done: got %0d expected 1", n_done - b_done); end
    endtask

    task automatic test_not_finish();
        bit ok;
        int b_rd, b_done, b_tmo;
        b_rd = n_rd; b_done = n_done; b_tmo = n_tmo;
        bad_val   = 8'h03;
        finish_at = n_rd + 2;
        kick_once();
        wait_idle(ok);
        bad_val = 8'h00;
        tests++;
        if (n_rd - b_rd != 2) begin fails++; $display("FAIL nf_reads: got %0d expected 2", n_rd - b_rd); end
        tests++;
        if (n_done - b_done != 1 || n_tmo != b_tmo) begin
            fails++; $display("FAIL nf_done: got done=%0d tmo=%0d expected 1 0", n_done - b_done, n_tmo - b_tmo);
        end
        tests++;
        if (poll_count !== 16'd2) begin fails++; $display("FAIL nf_poll_count: got %0d expected 2", poll_count); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int b_wr, b_fall, b_done;
        b_wr = n_wr; b_fall = n_bfall; b_done = n_done;
        finish_at = n_rd + 1;
        step();
        kick = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (n_bfall != b_fall) begin ok = 1'b1; break; end
        end
        step();
        finish_at = n_rd + 1;
        tests++;
        if (!ok || n_wr - b_wr != 2) begin
            fails++; $display("FAIL b2b_retrigger: got writes=%0d expected 2", n_wr - b_wr);
        end
        tests++;
        if (wr_cyc - bfall_cyc != 1) begin
            fails++; $display("FAIL b2b_idle_gap: got %0d expected 1", wr_cyc - bfall_cyc);
        end
        kick = 1'b0;
        wait_idle(ok);
        tests++;
        if (n_done - b_done != 2) begin fails++; $display("FAIL b2b_done: got %0d expected 2", n_done - b_done); end
    endtask

    task automatic test_reset_in_read();
        bit ok;
        int b_wr, b_rd, b_done;
        finish_at = -1;
        kick_once();
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (read) begin ok = 1'b1; break; end
        end
        reset = 1'b1;
        #1;
        tests++;
        if (!ok || read !== 1'b0 || poll_count !== 16'd0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_read: got read=%b poll=%0d busy=%b expected 0 0 0", read, poll_count, busy);
        end
        step();
        reset = 1'b0;
        b_wr = n_wr; b_rd = n_rd; b_done = n_done;
        repeat (3) step();
        tests++;
        if (n_wr != b_wr || busy !== 1'b0) begin
            fails++; $display("FAIL rst_idle: got writes=%0d busy=%b expected 0 0", n_wr - b_wr, busy);
        end
        finish_at = n_rd + 1;
        kick_once();
        wait_idle(ok);
        tests++;
        if (n_wr - b_wr != 1 || n_rd - b_rd != 1 || n_done - b_done != 1 || poll_count !== 16'd1) begin
            fails++;
            $display("FAIL rst_clean_txn: got wr=%0d rd=%0d done=%0d poll=%0d expected 1 1 1 1",
                     n_wr - b_wr, n_rd - b_rd, n_done - b_done, poll_count);
        end
    endtask

    task automatic test_exclusive();
        tests++;
        if (overlap != 0) begin fails++; $display("FAIL exclusive: got %0d overlaps expected 0", overlap); end
    endtask

    initial begin
        reset = 1'b1;
        kick  = 1'b0;
        test_reset();
        test_finish_third();
        test_timeout();
        test_kick_ignored();
        test_not_finish();
        test_back_to_back();
        test_reset_in_read();
        test_exclusive();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
